// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
// Holds the state encoding and the default bus widths.
package mem_copy_engine_pkg;

   localparam int ADR_W_DEF  = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Word-addressed data memory port.
// The memory answers reads combinationally and commits writes on the clock edge.
interface mem_copy_engine_if #(
   parameter int ADR_W  = mem_copy_engine_pkg::ADR_W_DEF,
   parameter int DATA_W = mem_copy_engine_pkg::DATA_W_DEF
);

   logic [ADR_W-1:0]  adr;
   logic [DATA_W-1:0] WriteData;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] ReadData;

   modport master (
      output adr,
      output WriteData,
      output MemRead,
      output MemWrite,
      input  ReadData
   );

   modport slave (
      input  adr,
      input  WriteData,
      input  MemRead,
      input  MemWrite,
      output ReadData
   );

endinterface

// File: rtl/mem_copy_engine.sv
// Block copy master: for each word, one read cycle then one write cycle, in ascending order.
// All memory-side outputs are registered, so they change only at the clock edge.
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int ADR_W  = ADR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADR_W-1:0]   src_adr,
   input  logic [ADR_W-1:0]   dst_adr,
   input  logic [LEN_W-1:0]   len,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [LEN_W-1:0]   words_done,
   mem_copy_engine_if.master  mem
);

   state_e             state_q, state_d;
   logic [ADR_W-1:0]   src_q, src_d;
   logic [ADR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;

   // Address arithmetic wraps modulo 2^ADR_W.
   function automatic logic [ADR_W-1:0] word_adr(input logic [ADR_W-1:0] base,
                                                 input logic [LEN_W-1:0] idx);
      return base + ADR_W'(idx);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         adr_q   <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // Memory outputs for the next cycle are decided here, so they are registered.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      adr_d   = '0;
      wdata_d = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d = src_adr;
               dst_d = dst_adr;
               len_d = len;
               cnt_d = '0;
               if (len != '0) begin
                  state_d = ST_READ;
                  adr_d   = src_adr;
                  rd_d    = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_READ: begin
            // An aborted read is simply dropped; nothing reaches the memory.
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
               adr_d   = word_adr(dst_q, cnt_q);
               wdata_d = mem.ReadData;
               wr_d    = 1'b1;
            end
         end
         ST_WRITE: begin
            // The memory commits on this edge regardless of abort, so always count it.
            cnt_d = cnt_q + LEN_W'(1);
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_d == len_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
               adr_d   = word_adr(src_q, cnt_d);
               rd_d    = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy          = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign done          = (state_q == ST_DONE);
   assign words_done    = cnt_q;
   assign mem.adr       = adr_q;
   assign mem.WriteData = wdata_q;
   assign mem.MemRead   = rd_q;
   assign mem.MemWrite  = wr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a 256-word memory responder, a transaction-level
// reference model producing per-cycle expectations, and directed copy scenarios.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_adr = '0;
   logic [31:0] dst_adr = '0;
   logic [15:0] len = '0;
   logic        abort = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] words_done;

   mem_copy_engine_if #(.ADR_W(32), .DATA_W(32)) mif ();

   mem_copy_engine #(.ADR_W(32), .DATA_W(32), .LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_adr    (src_adr),
      .dst_adr    (dst_adr),
      .len        (len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .words_done (words_done),
      .mem        (mif)
   );

   always #5 clk = ~clk;

   // Memory responder, indexed by the low address byte.
   logic [31:0] mem [256];
   logic        pl_en  = 1'b0;
   logic        pl_clr = 1'b0;
   logic [7:0]  pl_a   = '0;
   logic [31:0] pl_d   = '0;

   always @(posedge clk) begin
      if (pl_clr) begin
         for (int a = 0; a < 256; a++) mem[a] <= '0;
      end else if (mif.MemWrite) begin
         mem[mif.adr[7:0]] <= mif.WriteData;
      end else if (pl_en) begin
         mem[pl_a] <= pl_d;
      end
   end

   assign mif.ReadData = mif.MemRead ? mem[mif.adr[7:0]] : '0;

   // Reference model: expected bus cycles and a shadow memory.
   typedef struct {
      logic        busy;
      logic        done;
      logic        rd;
      logic        wr;
      logic        chk_adr;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [15:0] words;
      logic [15:0] words_after;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [256];
   logic [15:0] idle_words = '0;
   logic [31:0] rd_log[$];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Copy semantics: word k is read from src+k then written to dst+k, in ascending k.
   // abort_c names the copy cycle (1-based) during which abort is held high, 0 for none.
   function automatic void build(input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] n, input int abort_c);
      exp_t        e;
      logic [31:0] data;
      for (int k = 0; k < int'(n); k++) begin
         e = '{busy: 1'b1, done: 1'b0, rd: 1'b1, wr: 1'b0, chk_adr: 1'b1,
               adr: s + 32'(k), wd: '0, words: 16'(k), words_after: 16'(k)};
         exp_q.push_back(e);
         if (abort_c == 2*k + 1) return;
         data = ref_mem[8'(s + 32'(k))];
         e = '{busy: 1'b1, done: 1'b0, rd: 1'b0, wr: 1'b1, chk_adr: 1'b1,
               adr: d + 32'(k), wd: data, words: 16'(k), words_after: 16'(k + 1)};
         exp_q.push_back(e);
         ref_mem[8'(d + 32'(k))] = data;
         if (abort_c == 2*k + 2) return;
      end
      e = '{busy: 1'b0, done: 1'b1, rd: 1'b0, wr: 1'b0, chk_adr: 1'b0,
            adr: '0, wd: '0, words: n, words_after: n};
      exp_q.push_back(e);
   endfunction

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mif.MemRead) rd_log.push_back(mif.adr);
      if (!rst) begin
         check("rst_busy", {63'd0, busy}, 64'd0);
         check("rst_done", {63'd0, done}, 64'd0);
         check("rst_rd", {63'd0, mif.MemRead}, 64'd0);
         check("rst_wr", {63'd0, mif.MemWrite}, 64'd0);
         check("rst_adr", {32'd0, mif.adr}, 64'd0);
         check("rst_wd", {32'd0, mif.WriteData}, 64'd0);
         check("rst_words", {48'd0, words_done}, 64'd0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cyc_busy", {63'd0, busy}, {63'd0, e.busy});
         check("cyc_done", {63'd0, done}, {63'd0, e.done});
         check("cyc_rd", {63'd0, mif.MemRead}, {63'd0, e.rd});
         check("cyc_wr", {63'd0, mif.MemWrite}, {63'd0, e.wr});
         if (e.chk_adr) check("cyc_adr", {32'd0, mif.adr}, {32'd0, e.adr});
         if (e.wr) check("cyc_wd", {32'd0, mif.WriteData}, {32'd0, e.wd});
         check("cyc_words", {48'd0, words_done}, {48'd0, e.words});
         idle_words = e.words_after;
      end else begin
         check("idle_busy", {63'd0, busy}, 64'd0);
         check("idle_done", {63'd0, done}, 64'd0);
         check("idle_rd", {63'd0, mif.MemRead}, 64'd0);
         check("idle_wr", {63'd0, mif.MemWrite}, 64'd0);
         check("idle_adr", {32'd0, mif.adr}, 64'd0);
         check("idle_wd", {32'd0, mif.WriteData}, 64'd0);
         check("idle_words", {48'd0, words_done}, {48'd0, idle_words});
      end
   end

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      @(posedge clk);
      #1;
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = v;
      ref_mem[a] = v;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   // Runs one copy; reports the copy cycle in which done was seen and the busy cycle count.
   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int abort_c, input bit ab_with_start, input bit pulse_start,
                          output int done_at, output int busy_n);
      @(posedge clk);
      #1;
      start   = 1'b1;
      src_adr = s;
      dst_adr = d;
      len     = n;
      abort   = ab_with_start;
      @(posedge clk);
      build(s, d, n, abort_c);
      #1;
      start   = 1'b0;
      abort   = 1'b0;
      src_adr = 32'hDEAD_0000;
      dst_adr = 32'hDEAD_1000;
      len     = 16'd7;
      done_at = 0;
      busy_n  = 0;
      for (int c = 1; c <= 2*int'(n) + 3; c++) begin
         abort = (c == abort_c);
         start = pulse_start && (c == 3);
         if (done) done_at = c;
         if (busy) busy_n++;
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int done_at;
      int busy_n;
      for (int a = 0; a < 256; a++) ref_mem[a] = '0;

      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_adr", {32'd0, mif.adr}, 64'd0);
      check("reset_words", {48'd0, words_done}, 64'd0);
      pl_clr = 1'b1;
      @(posedge clk);
      #1;
      pl_clr = 1'b0;
      rst = 1'b1;

      preload(8'd100, 32'hA0A0_0001);
      preload(8'd101, 32'hB0B0_0002);
      preload(8'd102, 32'hC0C0_0003);
      preload(8'd103, 32'hD0D0_0004);
      preload(8'd0,   32'h0000_1234);
      preload(8'd255, 32'hAAAA_5555);
      preload(8'd9,   32'h0000_0099);
      preload(8'd10,  32'd7);
      preload(8'd11,  32'd1);
      preload(8'd12,  32'd2);
      preload(8'd13,  32'd3);
      for (int k = 0; k < 5; k++) preload(8'(20 + k), 32'h11 + 32'(k));

      // Straight four-word copy.
      do_copy(32'd100, 32'd200, 16'd4, 0, 1'b0, 1'b0, done_at, busy_n);
      check("t1_done_at", 64'(done_at), 64'd9);
      check("t1_busy_n", 64'(busy_n), 64'd8);
      check("t1_words", {48'd0, words_done}, 64'd4);
      check("t1_m200", {32'd0, mem[200]}, 64'hA0A0_0001);
      check("t1_m201", {32'd0, mem[201]}, 64'hB0B0_0002);
      check("t1_m202", {32'd0, mem[202]}, 64'hC0C0_0003);
      check("t1_m203", {32'd0, mem[203]}, 64'hD0D0_0004);

      // Zero-length copy.
      do_copy(32'd5, 32'd9, 16'd0, 0, 1'b0, 1'b0, done_at, busy_n);
      check("t2_done_at", 64'(done_at), 64'd1);
      check("t2_busy_n", 64'(busy_n), 64'd0);
      check("t2_words", {48'd0, words_done}, 64'd0);
      check("t2_m9", {32'd0, mem[9]}, 64'h99);

      // Overlapping forward copy, with abort raised together with start.
      do_copy(32'd10, 32'd11, 16'd3, 0, 1'b1, 1'b0, done_at, busy_n);
      check("t3_done_at", 64'(done_at), 64'd7);
      check("t3_m11", {32'd0, mem[11]}, 64'd7);
      check("t3_m12", {32'd0, mem[12]}, 64'd7);
      check("t3_m13", {32'd0, mem[13]}, 64'd7);

      // Abort on the edge ending the second write.
      do_copy(32'd20, 32'd40, 16'd5, 4, 1'b0, 1'b0, done_at, busy_n);
      check("t4_done_at", 64'(done_at), 64'd0);
      check("t4_words", {48'd0, words_done}, 64'd2);
      check("t4_m40", {32'd0, mem[40]}, 64'h11);
      check("t4_m41", {32'd0, mem[41]}, 64'h12);
      check("t4_m42", {32'd0, mem[42]}, 64'd0);

      // Abort on the edge ending the third read.
      do_copy(32'd20, 32'd70, 16'd5, 5, 1'b0, 1'b0, done_at, busy_n);
      check("t5_done_at", 64'(done_at), 64'd0);
      check("t5_words", {48'd0, words_done}, 64'd2);
      check("t5_m71", {32'd0, mem[71]}, 64'h12);
      check("t5_m72", {32'd0, mem[72]}, 64'd0);

      // Asynchronous reset mid-copy.
      @(posedge clk);
      #1;
      start = 1'b1; src_adr = 32'd100; dst_adr = 32'd60; len = 16'd4;
      @(posedge clk);
      build(32'd100, 32'd60, 16'd4, 0);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      idle_words = '0;
      #1;
      check("t6_async_busy", {63'd0, busy}, 64'd0);
      check("t6_async_rd", {63'd0, mif.MemRead}, 64'd0);
      check("t6_async_wr", {63'd0, mif.MemWrite}, 64'd0);
      check("t6_async_adr", {32'd0, mif.adr}, 64'd0);
      check("t6_async_words", {48'd0, words_done}, 64'd0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      check("t6_m60", {32'd0, mem[60]}, 64'hA0A0_0001);
      check("t6_m61", {32'd0, mem[61]}, 64'd0);
      do_copy(32'd0, 32'd50, 16'd1, 0, 1'b0, 1'b0, done_at, busy_n);
      check("t6_done_at", 64'(done_at), 64'd3);
      check("t6_m50", {32'd0, mem[50]}, 64'h1234);
      check("t6_words", {48'd0, words_done}, 64'd1);

      // Source address wrap, with a start pulse while busy.
      rd_log.delete();
      do_copy(32'hFFFF_FFFF, 32'd30, 16'd2, 0, 1'b0, 1'b1, done_at, busy_n);
      check("t7_nreads", 64'(rd_log.size()), 64'd2);
      if (rd_log.size() == 2) begin
         check("t7_rd0", {32'd0, rd_log[0]}, 64'hFFFF_FFFF);
         check("t7_rd1", {32'd0, rd_log[1]}, 64'h0000_0000);
      end
      check("t7_done_at", 64'(done_at), 64'd5);
      check("t7_m30", {32'd0, mem[30]}, 64'hAAAA_5555);
      check("t7_m31", {32'd0, mem[31]}, 64'h1234);
      check("t7_words", {48'd0, words_done}, 64'd2);

      repeat (3) @(posedge clk);
      #1;
      check("end_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
